// File: rtl/cdc_event_arbiter_if.sv
// Bundle of request, status and toggle-handshake signals between the event
// sources / CDC destination (master side) and cdc_event_arbiter (slave side).
interface cdc_event_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_pulse;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] overflow;
  logic [ID_W-1:0]  xfer_id;
  logic             xfer_toggle;
  logic             ack_toggle;
  logic [N_REQ-1:0] done;
  logic             busy;

  modport slave (
    input  req_pulse,
    input  ack_toggle,
    output pending,
    output overflow,
    output xfer_id,
    output xfer_toggle,
    output done,
    output busy
  );

  modport master (
    output req_pulse,
    output ack_toggle,
    input  pending,
    input  overflow,
    input  xfer_id,
    input  xfer_toggle,
    input  done,
    input  busy
  );
endinterface

// File: rtl/cdc_event_arbiter.sv
// Shares one two-phase toggle CDC channel between N_REQ single-cycle event
// sources. Events latch into pending bits, a round-robin arbiter picks one,
// its ID is presented as bundled data for a full cycle before xfer_toggle
// flips, and the next event waits until the destination echoes the toggle.
// SYNC_STAGES must be at least 2.
module cdc_event_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  cdc_event_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   overflow_q, overflow_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [ID_W-1:0]    xfer_id_q, xfer_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               toggle_q, toggle_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic               ack_sync;

  logic [2*N_REQ-1:0] pend_dbl;
  logic [N_REQ-1:0]   pend_rot;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    win;
  logic               found;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // Bring the destination's echo toggle into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_toggle};
    end
  end

  // Round-robin search: rotate pending so rr_ptr sits at bit 0, take the
  // first set bit, then map the offset back to a source index.
  always_comb begin
    int s;
    pend_dbl = {pending_q, pending_q} >> rr_ptr_q;
    pend_rot = pend_dbl[N_REQ-1:0];
    found    = 1'b0;
    win      = '0;
    s        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && pend_rot[k]) begin
        found = 1'b1;
        s     = int'(rr_ptr_q) + k;
        if (s >= N_REQ) s = s - N_REQ;
        win   = ID_W'(s);
      end
    end
  end

  // Next-state logic for the handshake FSM and the pending/overflow bits.
  always_comb begin
    state_d   = state_q;
    xfer_id_d = xfer_id_q;
    toggle_d  = toggle_q;
    rr_ptr_d  = rr_ptr_q;
    done_d    = '0;
    grant     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant     = N_REQ'(1) << win;
          xfer_id_d = win;
          rr_ptr_d  = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        // xfer_id has now been stable for a full cycle; publish the event.
        toggle_d = ~toggle_q;
        state_d  = WAIT;
      end
      WAIT: begin
        if (ack_sync == toggle_q) begin
          done_d  = N_REQ'(1) << xfer_id_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A request arriving in its own grant cycle is a fresh event, not a merge.
    pending_d  = (pending_q & ~grant) | bus.req_pulse;
    overflow_d = bus.req_pulse & pending_q & ~grant;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      done_q     <= '0;
      xfer_id_q  <= '0;
      rr_ptr_q   <= '0;
      toggle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      xfer_id_q  <= xfer_id_d;
      rr_ptr_q   <= rr_ptr_d;
      toggle_q   <= toggle_d;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.overflow    = overflow_q;
  assign bus.done        = done_q;
  assign bus.xfer_id     = xfer_id_q;
  assign bus.xfer_toggle = toggle_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Bench for cdc_event_arbiter: a per-cycle vector table for a single event,
// hand-written sequences for fairness, merge, grant collision, stall and
// mid-transfer reset, and a scoreboard of expected done IDs.
module tb_cdc_event_arbiter;
  logic clk;
  logic rst;
  logic auto_ack;
  logic man_ack;
  logic dst_tog;

  int errors = 0;
  int checks = 0;
  int sb[$];

  cdc_event_arbiter_if #(.N_REQ(4)) bus ();

  cdc_event_arbiter #(.N_REQ(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Destination model: echoes xfer_toggle one cycle later; reset together.
  always @(posedge clk or posedge rst) begin
    if (rst) dst_tog <= 1'b0;
    else if (auto_ack) dst_tog <= bus.xfer_toggle;
  end

  assign bus.ack_toggle = auto_ack ? dst_tog : man_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the next expected source ID.
  always @(negedge clk) begin
    if (!rst && bus.done !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got %b expected none", bus.done);
      end else begin
        int e;
        logic [3:0] ev;
        e  = sb.pop_front();
        ev = 4'b0001 << e;
        if (bus.done !== ev) begin
          errors++;
          $display("FAIL done_order: got %b expected %b", bus.done, ev);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_pulse = 4'b0000;
    man_ack = 1'b0;
    auto_ack = 1'b0;
    sb.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy || bus.pending != 4'b0000) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drained"}, {31'd0, (sb.size() == 0 && !bus.busy)}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [1:0] id;
    logic       tog;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    bus.req_pulse = 4'b0000;
    man_ack = 1'b0;
    auto_ack = 1'b0;

    //            req      ack   pend     ovf      id    tog   done     busy
    tbl[0] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1};
    tbl[2] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0000, 1'b1};
    tbl[3] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0000, 1'b1};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b0};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0000, 1'b0};

    step();
    step();
    rst = 1'b0;
    step();
    check("rst_pending",  {28'd0, bus.pending},  32'd0);
    check("rst_overflow", {28'd0, bus.overflow}, 32'd0);
    check("rst_id",       {30'd0, bus.xfer_id},  32'd0);
    check("rst_toggle",   {31'd0, bus.xfer_toggle}, 32'd0);
    check("rst_done",     {28'd0, bus.done},     32'd0);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);

    // Single event, cycle by cycle with a manual echo.
    sb.push_back(2);
    for (int i = 0; i < 7; i++) begin
      bus.req_pulse = tbl[i].req;
      man_ack = tbl[i].ack;
      step();
      check($sformatf("v%0d_pending", i),  {28'd0, bus.pending},     {28'd0, tbl[i].pend});
      check($sformatf("v%0d_overflow", i), {28'd0, bus.overflow},    {28'd0, tbl[i].ovf});
      check($sformatf("v%0d_id", i),       {30'd0, bus.xfer_id},     {30'd0, tbl[i].id});
      check($sformatf("v%0d_toggle", i),   {31'd0, bus.xfer_toggle}, {31'd0, tbl[i].tog});
      check($sformatf("v%0d_done", i),     {28'd0, bus.done},        {28'd0, tbl[i].done});
      check($sformatf("v%0d_busy", i),     {31'd0, bus.busy},        {31'd0, tbl[i].busy});
    end
    bus.req_pulse = 4'b0000;
    check("single_sb_empty", sb.size(), 0);

    // Fairness: all four at once, then wrap-around of the pointer.
    apply_reset();
    auto_ack = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    bus.req_pulse = 4'b1111;
    step();
    bus.req_pulse = 4'b0000;
    wait_drain("fair4", 200);
    check("fair4_toggle", {31'd0, bus.xfer_toggle}, 32'd0);
    sb.push_back(0); sb.push_back(1);
    bus.req_pulse = 4'b0011;
    step();
    bus.req_pulse = 4'b0000;
    wait_drain("fair2", 200);
    sb.push_back(2); sb.push_back(0);
    bus.req_pulse = 4'b0101;
    step();
    bus.req_pulse = 4'b0000;
    wait_drain("fair_rr", 200);

    // Overflow: source 1 pulses twice while source 0 is in flight.
    apply_reset();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = 4'b0000;
    step();
    step();
    check("ovf_in_wait", {31'd0, bus.busy}, 32'd1);
    bus.req_pulse = 4'b0010;
    step();
    check("ovf_first", {28'd0, bus.overflow}, 32'd0);
    step();
    check("ovf_second", {28'd0, bus.overflow}, 32'b0010);
    bus.req_pulse = 4'b0000;
    step();
    check("ovf_one_cycle", {28'd0, bus.overflow}, 32'd0);
    check("ovf_pending", {28'd0, bus.pending}, 32'b0010);
    sb.push_back(0); sb.push_back(1);
    auto_ack = 1'b1;
    wait_drain("ovf", 200);

    // Grant collision: a new request in the cycle its source is granted.
    apply_reset();
    bus.req_pulse = 4'b0010;
    step();
    step();
    bus.req_pulse = 4'b0000;
    check("coll_overflow", {28'd0, bus.overflow}, 32'd0);
    check("coll_pending",  {28'd0, bus.pending},  32'b0010);
    check("coll_id",       {30'd0, bus.xfer_id},  32'd1);
    sb.push_back(1); sb.push_back(1);
    auto_ack = 1'b1;
    wait_drain("coll", 200);

    // Stall: no echo for 1000 cycles.
    apply_reset();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = 4'b0000;
    step();
    step();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.req_pulse = (i == 100) ? 4'b0100 : 4'b0000;
      step();
      if (bus.xfer_id !== 2'd0 || bus.xfer_toggle !== 1'b1 || bus.busy !== 1'b1) bad++;
    end
    bus.req_pulse = 4'b0000;
    check("stall_stable", bad, 0);
    check("stall_pending", {28'd0, bus.pending}, 32'b0100);
    sb.push_back(0); sb.push_back(2);
    auto_ack = 1'b1;
    wait_drain("stall", 300);

    // Reset while waiting for an echo.
    apply_reset();
    bus.req_pulse = 4'b0100;
    step();
    bus.req_pulse = 4'b0000;
    step();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = 4'b0000;
    step();
    check("rstw_pre_busy", {31'd0, bus.busy}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rstw_pending",  {28'd0, bus.pending},  32'd0);
    check("rstw_id",       {30'd0, bus.xfer_id},  32'd0);
    check("rstw_toggle",   {31'd0, bus.xfer_toggle}, 32'd0);
    check("rstw_busy",     {31'd0, bus.busy},     32'd0);
    check("rstw_done_ovf", {28'd0, bus.done | bus.overflow}, 32'd0);
    step();
    rst = 1'b0;
    step();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = 4'b0000;
    step();
    check("rstw_tog_before", {31'd0, bus.xfer_toggle}, 32'd0);
    step();
    check("rstw_tog_after", {31'd0, bus.xfer_toggle}, 32'd1);
    sb.push_back(0);
    auto_ack = 1'b1;
    wait_drain("rstw", 200);

    repeat (5) step();
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
